// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register file write-back arbiter (ALU + long-unit FIFO) with pending-destination scoreboard
module reg_wb_ctrl #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            RegWEn,
    output logic [4:0]      rsW,
    output logic [XLEN-1:0] dataW
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     LP_DEPTH = (PW+1)'(FIFO_DEPTH);

    logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [31:0]     r_pending;
    logic            r_regwen;
    logic [4:0]      r_rsw;
    logic [XLEN-1:0] r_dataw;

    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [31:0]     w_pending_nxt;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign lu_ready    = rst & (r_count < LP_DEPTH);
    assign w_push      = lu_valid & lu_ready;
    assign w_pop       = ~alu_valid & (r_count != '0);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    assign hazard = r_pending[chk_rs1] | r_pending[chk_rs2] | r_pending[chk_rd];

    assign RegWEn = r_regwen;
    assign rsW    = r_rsw;
    assign dataW  = r_dataw;

    // Set is applied after clear so a same-edge reissue keeps the register pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop && (w_head_rd != 5'd0)) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= lu_rd;
            r_fifo_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwen <= 1'b0;
            r_rsw    <= 5'd0;
            r_dataw  <= '0;
        end else if (alu_valid) begin
            r_regwen <= (alu_rd != 5'd0);
            r_rsw    <= alu_rd;
            r_dataw  <= alu_data;
        end else if (w_pop) begin
            r_regwen <= (w_head_rd != 5'd0);
            r_rsw    <= w_head_rd;
            r_dataw  <= w_head_data;
        end else begin
            r_regwen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - vector table and scoreboard bench for reg_wb_ctrl
module tb_reg_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        RegWEn;
    logic [4:0]  rsW;
    logic [31:0] dataW;

    reg_wb_ctrl #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .RegWEn(RegWEn), .rsW(rsW), .dataW(dataW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        lu_v;
        logic [4:0]  lu_rd;
        logic [31:0] lu_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        exp_ready;
        logic        exp_haz;
    } vec_t;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] d;
    } alu_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } lu_exp_t;

    alu_exp_t alu_q[$];
    lu_exp_t  lu_q[$];
    vec_t     vecs[$];
    int       cyc    = 0;
    int       n_vec  = 0;
    int       n_bad  = 0;

    function automatic vec_t mk(
        input logic alu_v, input logic [4:0] a_rd, input logic [31:0] a_d,
        input logic lu_v, input logic [4:0] l_rd, input logic [31:0] l_d,
        input logic iss_v, input logic [4:0] i_rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic exp_ready, input logic exp_haz);
        vec_t v;
        v.alu_v = alu_v; v.alu_rd = a_rd; v.alu_d = a_d;
        v.lu_v = lu_v; v.lu_rd = l_rd; v.lu_d = l_d;
        v.iss_v = iss_v; v.iss_rd = i_rd;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.exp_ready = exp_ready; v.exp_haz = exp_haz;
        return v;
    endfunction

    function automatic vec_t idle(input logic [4:0] rs1, input logic [4:0] rd,
                                  input logic exp_ready, input logic exp_haz);
        return mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                  rs1, 5'd0, rd, exp_ready, exp_haz);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Registered write port: ALU writes are due exactly one cycle after drive; long-unit writes drain in order.
    task automatic monitor();
        alu_exp_t a;
        lu_exp_t  l;
        if (alu_q.size() > 0 && alu_q[0].due == cyc) begin
            a = alu_q.pop_front();
            if (a.rd != 5'd0)
                chk("alu_write", {26'd0, RegWEn, rsW, dataW}, {26'd0, 1'b1, a.rd, a.d});
            else
                chk("alu_x0_wen", {63'd0, RegWEn}, 64'd0);
        end else if (RegWEn === 1'b1) begin
            if (lu_q.size() > 0) begin
                l = lu_q.pop_front();
                chk("lu_write", {27'd0, rsW, dataW}, {27'd0, l.rd, l.d});
            end else begin
                chk("spurious_write", {63'd0, RegWEn}, 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic apply(input vec_t v, input string name);
        alu_exp_t a;
        lu_exp_t  l;
        alu_valid = v.alu_v; alu_rd = v.alu_rd; alu_data = v.alu_d;
        lu_valid  = v.lu_v;  lu_rd  = v.lu_rd;  lu_data  = v.lu_d;
        iss_valid = v.iss_v; iss_rd = v.iss_rd;
        chk_rs1 = v.rs1; chk_rs2 = v.rs2; chk_rd = v.rd;
        if (v.alu_v) begin
            a.due = cyc + 1; a.rd = v.alu_rd; a.d = v.alu_d;
            alu_q.push_back(a);
        end
        if (v.lu_v && v.exp_ready && v.lu_rd != 5'd0) begin
            l.rd = v.lu_rd; l.d = v.lu_d;
            lu_q.push_back(l);
        end
        #1;
        chk({name, "_ready"},  {63'd0, lu_ready}, {63'd0, v.exp_ready});
        chk({name, "_hazard"}, {63'd0, hazard},   {63'd0, v.exp_haz});
    endtask

    task automatic run(input vec_t v, input string name);
        apply(v, name);
        step();
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'h0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

        #12;
        chk("rst_regwen",   {63'd0, RegWEn},   64'd0);
        chk("rst_rsw",      {59'd0, rsW},      64'd0);
        chk("rst_dataw",    {32'd0, dataW},    64'd0);
        chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
        chk("rst_hazard",   {63'd0, hazard},   64'd0);
        #11 rst = 1'b1;
        step();

        // ALU single write, issue/long-unit write with hazard window, x0 from both sources, WAW check
        vecs.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(idle(5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b1));
        vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1));
        vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b1));
        vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(idle(5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0));
        vecs.push_back(idle(5'd0, 5'd12, 1'b1, 1'b1));
        vecs.push_back(idle(5'd0, 5'd0, 1'b1, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // ALU held high starves the FIFO; third offer stalls until a slot frees
        run(mk(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "starve0");
        run(mk(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "starve1");
        run(mk(1'b1, 5'd12, 32'hA2, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), "starve2");
        run(mk(1'b1, 5'd13, 32'hA3, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), "starve3");
        run(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), "drain0");
        run(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "drain1");
        run(idle(5'd0, 5'd0, 1'b1, 1'b0), "drain2");
        run(idle(5'd0, 5'd0, 1'b1, 1'b0), "drain3");

        // Pop of rd=9 on the same edge as a reissue to rd=9: set wins
        run(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0), "waw0");
        run(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1), "waw1");
        run(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1), "waw2");
        run(idle(5'd0, 5'd9, 1'b1, 1'b1), "waw3");
        run(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h98, 1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1), "waw4");
        run(idle(5'd0, 5'd9, 1'b1, 1'b1), "waw5");
        run(idle(5'd0, 5'd9, 1'b1, 1'b0), "waw6");

        // Full FIFO plus pending bits, then asynchronous reset mid-cycle
        run(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "rst0");
        run(mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "rst1");
        run(mk(1'b1, 5'd2, 32'h22, 1'b1, 5'd16, 32'h16, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "rst2");
        apply(mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd15, 5'd0, 5'd0, 1'b0, 1'b1), "rst3");
        #2 rst = 1'b0;
        #1;
        chk("async_rst_regwen",   {63'd0, RegWEn},   64'd0);
        chk("async_rst_lu_ready", {63'd0, lu_ready}, 64'd0);
        chk("async_rst_hazard",   {63'd0, hazard},   64'd0);
        alu_q.delete();
        lu_q.delete();
        alu_valid = 1'b0; lu_valid = 1'b0; iss_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        run(idle(5'd15, 5'd16, 1'b1, 1'b0), "post0");
        run(idle(5'd0, 5'd0, 1'b1, 1'b0), "post1");
        run(idle(5'd0, 5'd0, 1'b1, 1'b0), "post2");
        run(mk(1'b1, 5'd6, 32'h66, 1'b1, 5'd17, 32'h17, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0), "post3");
        for (int i = 0; i < 4; i++) begin
            run(idle(5'd0, 5'd0, 1'b1, 1'b0), $sformatf("tail%0d", i));
        end

        chk("alu_queue_drained", 64'(alu_q.size()), 64'd0);
        chk("lu_queue_drained",  64'(lu_q.size()),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
